dmi_uart_frame_tx: RTL and testbench

Host-side frame encoder that produces the byte stream consumed by the DMI UART TAP receiver.
- Takes one request (cmd, address, length, data word) per handshake.
- Emits HEADER, cmd/addr byte, length byte, then data bytes LSB-first, over a byte-wide valid/ready link to the UART transmitter.
- Used in the debug-host bridge and as the stimulus driver in TAP benches.

---
 rtl/dmi_uart_frame_tx.sv | 158 +++++++++++++++
 tb/tb_dmi_uart_frame_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmi_uart_frame_tx.sv
// Host-side DMI UART frame encoder: HEADER, {cmd,addr}, len, then data bytes LSB-first
// over a byte-wide valid/ready link. Over-length requests are rejected with a pulse.
module dmi_uart_frame_tx #(
    parameter int          IrLength = 5,
    parameter logic [7:0]  HEADER   = 8'h01,
    parameter int          MAX_LEN  = 4,
    parameter int          DATA_W   = 8 * MAX_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [7-IrLength:0]   req_cmd_i,
    input  logic [IrLength-1:0]   req_addr_i,
    input  logic [7:0]            req_len_i,
    input  logic [DATA_W-1:0]     req_data_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_len_o
);

    localparam int         CMD_W     = 8 - IrLength;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CMDADDR,
        ST_LENGTH,
        ST_DATA
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          count_q, count_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                capture;
    logic                handshake;

    logic [CMD_W-1:0]    cmd_q;
    logic [IrLength-1:0] addr_q;
    logic [7:0]          len_q;
    logic [DATA_W-1:0]   data_q;

    function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] d, input logic [7:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (idx == 8'(k)) r = d[8*k +: 8];
        end
        return r;
    endfunction

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_valid_o  = (state_q != ST_IDLE);
    assign tx_data_o   = tx_data_q;
    assign done_o      = done_q;
    assign err_len_o   = err_q;
    assign handshake   = tx_valid_o & tx_ready_i;

    // tx_data_d is loaded only when the state advances, so a stalled byte holds
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_len_i > MAX_LEN_B) begin
                        err_d = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_d   = ST_HEADER;
                        tx_data_d = HEADER;
                    end
                end
            end
            ST_HEADER: begin
                if (handshake) begin
                    state_d   = ST_CMDADDR;
                    tx_data_d = {cmd_q, addr_q};
                end
            end
            ST_CMDADDR: begin
                if (handshake) begin
                    state_d   = ST_LENGTH;
                    tx_data_d = len_q;
                end
            end
            ST_LENGTH: begin
                if (handshake) begin
                    if (len_q != 8'd0) begin
                        state_d   = ST_DATA;
                        count_d   = 8'd0;
                        tx_data_d = byte_at(data_q, 8'd0);
                    end else begin
                        state_d   = ST_IDLE;
                        tx_data_d = 8'h00;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (handshake) begin
                    if (count_q == len_q - 8'd1) begin
                        state_d   = ST_IDLE;
                        count_d   = 8'd0;
                        tx_data_d = 8'h00;
                        done_d    = 1'b1;
                    end else begin
                        count_d   = count_q + 8'd1;
                        tx_data_d = byte_at(data_q, count_q + 8'd1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                count_d   = 8'd0;
                tx_data_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= 8'd0;
            tx_data_q <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (capture) begin
                cmd_q  <= req_cmd_i;
                addr_q <= req_addr_i;
                len_q  <= req_len_i;
                data_q <= req_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dmi_uart_frame_tx.sv
// Directed bench for dmi_uart_frame_tx: table of frames plus backpressure, length
// rejection, mid-frame reset and back-to-back sequences.
module tb_dmi_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [4:0]  req_addr;
    logic [7:0]  req_len;
    logic [31:0] req_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        err_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmi_uart_frame_tx #(.IrLength(5), .HEADER(8'h01), .MAX_LEN(4), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_len_i(req_len), .req_data_i(req_data),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .done_o(done), .err_len_o(err_len)
    );

    typedef struct packed {
        logic [2:0]      cmd;
        logic [4:0]      addr;
        logic [7:0]      len;
        logic [31:0]     data;
        logic [6:0][7:0] exp;
        logic [3:0]      n;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] c, input logic [4:0] a, input logic [7:0] l, input logic [31:0] d);
        req_cmd  = c;
        req_addr = a;
        req_len  = l;
        req_data = d;
    endtask

    // Caller is #1 after an edge; request is accepted at the next edge (N)
    task automatic run_frame(input vec_t v, input string tag);
        set_req(v.cmd, v.addr, v.len, v.data);
        req_valid = 1'b1;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        for (int i = 0; i < int'(v.n); i++) begin
            @(negedge clk);
            check($sformatf("%s byte%0d", tag, i), {22'd0, busy, tx_valid, tx_data}, {22'd0, 1'b1, 1'b1, v.exp[i]});
            next_cycle();
        end
        @(negedge clk);
        check({tag, " done"}, {29'd0, done, tx_valid, req_ready}, {29'd0, 1'b1, 1'b0, 1'b1});
        next_cycle();
        @(negedge clk);
        check({tag, " done_clear"}, 32'(done), 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got [$];
        logic [7:0] exp_bp [5];
        logic [7:0] prev;
        logic       stalled;
        logic       seen_done;
        logic [3:0] pat;
        logic [9:0] bb_valid;
        logic [9:0][7:0] bb_data;

        vecs[0] = '{cmd: 3'd1, addr: 5'h11, len: 8'd4, data: 32'hDEADBEEF,
                    exp: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h04, 8'h31, 8'h01}, n: 4'd7};
        vecs[1] = '{cmd: 3'd0, addr: 5'h10, len: 8'd0, data: 32'hFFFFFFFF,
                    exp: {32'h0, 8'h00, 8'h10, 8'h01}, n: 4'd3};
        vecs[2] = '{cmd: 3'd2, addr: 5'h1F, len: 8'd1, data: 32'h000000A5,
                    exp: {24'h0, 8'hA5, 8'h01, 8'h5F, 8'h01}, n: 4'd4};
        vecs[3] = '{cmd: 3'd7, addr: 5'h00, len: 8'd3, data: 32'h00C0FFEE,
                    exp: {8'h00, 8'hC0, 8'hFF, 8'hEE, 8'h03, 8'hE0, 8'h01}, n: 4'd6};

        rst = 1'b1;
        req_valid = 1'b0;
        tx_ready = 1'b1;
        set_req(3'd0, 5'd0, 8'd0, 32'd0);
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset outputs", {26'd0, tx_valid, busy, done, err_len, req_ready, 1'b0},
              {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        check("reset tx_data", 32'(tx_data), 32'd0);
        next_cycle();

        for (int k = 0; k < 4; k++) run_frame(vecs[k], $sformatf("vec%0d", k));

        // Backpressure: ready pattern 1,0,0,1 repeating
        set_req(3'd1, 5'h0A, 8'd2, 32'h00001234);
        req_valid = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        pat = 4'b1001;
        stalled = 1'b0;
        seen_done = 1'b0;
        prev = 8'h00;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tx_ready = pat[c % 4];
            @(negedge clk);
            if (stalled) check("bp hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev});
            if (tx_valid && tx_ready) got.push_back(tx_data);
            stalled = tx_valid && !tx_ready;
            prev = tx_data;
            if (done) seen_done = 1'b1;
            next_cycle();
        end
        tx_ready = 1'b1;
        check("bp done seen", 32'(seen_done), 32'd1);
        check("bp byte count", 32'(got.size()), 32'd5);
        exp_bp = '{8'h01, 8'h2A, 8'h02, 8'h34, 8'h12};
        for (int i = 0; i < 5 && i < got.size(); i++)
            check($sformatf("bp byte%0d", i), 32'(got[i]), 32'(exp_bp[i]));
        next_cycle();

        // Over-length request is rejected
        set_req(3'd1, 5'h03, 8'd5, 32'h11223344);
        req_valid = 1'b1;
        @(negedge clk);
        check("err req_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("err pulse", {29'd0, err_len, tx_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
        next_cycle();
        @(negedge clk);
        check("err clear", {29'd0, err_len, tx_valid, busy}, {29'd0, 1'b0, 1'b0, 1'b0});
        next_cycle();

        // Reset during the second data byte
        set_req(3'd1, 5'h11, 8'd4, 32'hDEADBEEF);
        req_valid = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("pre-reset byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBE});
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("abort outputs", {28'd0, tx_valid, busy, req_ready, done}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        check("abort tx_data", 32'(tx_data), 32'd0);
        next_cycle();
        run_frame(vecs[2], "post_reset");

        // Back-to-back with req_valid held; inputs change mid-frame
        bb_valid = 10'b1111101111;
        bb_data  = {8'h55, 8'h66, 8'h02, 8'h31, 8'h01, 8'h00, 8'hA5, 8'h01, 8'h5F, 8'h01};
        set_req(3'd2, 5'h1F, 8'd1, 32'h000000A5);
        req_valid = 1'b1;
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            if (i == 1) set_req(3'd1, 5'h11, 8'd2, 32'h00005566);
            if (i == 5) req_valid = 1'b0;
            @(negedge clk);
            check($sformatf("b2b cyc%0d", i), {23'd0, tx_valid, tx_data}, {23'd0, bb_valid[i], bb_data[i]});
            if (i == 4) check("b2b gap done", {30'd0, done, req_ready}, {30'd0, 1'b1, 1'b1});
            next_cycle();
        end
        @(negedge clk);
        check("b2b final done", {31'd0, done}, 32'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
